// File: rtl/aes_pkg.sv
// Shared constants and index helpers for the Rijndael ShiftRows datapath.
package aes_pkg;

  localparam int TAG_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_FULL_SKID = 2'd2
  } srp_state_t;

  function automatic bit nb_ok(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Rijndael row offsets; the 256-bit block uses a wider spread on rows 2 and 3.
  function automatic int shift_off(input int row, input int nb);
    if (nb == 8) begin
      case (row)
        0:       return 0;
        1:       return 1;
        2:       return 3;
        default: return 4;
      endcase
    end
    return row;
  endfunction

  function automatic int byte_idx(input int row, input int col);
    return 4 * col + row;
  endfunction

endpackage

// File: rtl/shift_row_net.sv
// Combinational ShiftRows / InvShiftRows byte permutation for Nb = 4, 6 or 8.
module shift_row_net
  import aes_pkg::*;
#(
  parameter  int NB = 4,
  localparam int W  = 32 * NB
) (
  input  logic [W-1:0] i_Data,
  input  logic         i_fEncrypt,
  output logic [W-1:0] o_Data
);

  if (!nb_ok(NB)) begin : g_bad_nb
    $error("shift_row_net: NB must be 4, 6 or 8");
  end

  // Byte 0 is the MSB byte; each output byte picks its source column per mode.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int OFF   = shift_off(r, NB);
      localparam int DST   = W - 1 - 8 * byte_idx(r, c);
      localparam int SRC_E = W - 1 - 8 * byte_idx(r, (c + OFF) % NB);
      localparam int SRC_D = W - 1 - 8 * byte_idx(r, (c + NB - OFF) % NB);
      assign o_Data[DST -: 8] = i_fEncrypt ? i_Data[SRC_E -: 8] : i_Data[SRC_D -: 8];
    end
  end

endmodule

// File: rtl/shift_row_pipe.sv
// Registered ShiftRows stage with valid/ready handshake, mode and tag sideband.
// Optional one-entry skid buffer with registered o_Ready: define SHIFTROW_SKID_EN.
module shift_row_pipe
  import aes_pkg::*;
#(
  parameter  int NB    = 4,
  parameter  int TAG_W = TAG_W_DEF,
  localparam int W     = 32 * NB
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [W-1:0]     i_Data,
  input  logic             i_fEncrypt,
  input  logic [TAG_W-1:0] i_Tag,
  input  logic             i_Valid,
  output logic             o_Ready,
  output logic [W-1:0]     o_Data,
  output logic             o_fEncrypt,
  output logic [TAG_W-1:0] o_Tag,
  output logic             o_Valid,
  input  logic             i_Ready
);

  logic [W-1:0]     perm_p0;
  logic [W-1:0]     data_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             enc_p1;
  logic             vld_p1;

  shift_row_net #(.NB(NB)) u_net (
    .i_Data     (i_Data),
    .i_fEncrypt (i_fEncrypt),
    .o_Data     (perm_p0)
  );

  // ---- stage p0 -> p1: output register (plus skid entry when enabled) ----
`ifdef SHIFTROW_SKID_EN
  srp_state_t       state;
  logic [W-1:0]     skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_enc;
  logic             skid_vld;
  logic             rdy_p1;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= ST_EMPTY;
      vld_p1    <= 1'b0;
      skid_vld  <= 1'b0;
      rdy_p1    <= 1'b1;
      data_p1   <= '0;
      tag_p1    <= '0;
      enc_p1    <= 1'b0;
      skid_data <= '0;
      skid_tag  <= '0;
      skid_enc  <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (i_Valid) begin
            data_p1 <= perm_p0;
            tag_p1  <= i_Tag;
            enc_p1  <= i_fEncrypt;
            vld_p1  <= 1'b1;
            state   <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (i_Ready) begin
            if (i_Valid) begin
              data_p1 <= perm_p0;
              tag_p1  <= i_Tag;
              enc_p1  <= i_fEncrypt;
            end else begin
              vld_p1 <= 1'b0;
              state  <= ST_EMPTY;
            end
          end else if (i_Valid) begin
            // Output stalled: park the new block so nothing upstream is lost.
            skid_data <= perm_p0;
            skid_tag  <= i_Tag;
            skid_enc  <= i_fEncrypt;
            skid_vld  <= 1'b1;
            rdy_p1    <= 1'b0;
            state     <= ST_FULL_SKID;
          end
        end
        ST_FULL_SKID: begin
          if (i_Ready) begin
            data_p1  <= skid_data;
            tag_p1   <= skid_tag;
            enc_p1   <= skid_enc;
            skid_vld <= 1'b0;
            rdy_p1   <= 1'b1;
            state    <= ST_FULL;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          vld_p1   <= 1'b0;
          skid_vld <= 1'b0;
          rdy_p1   <= 1'b1;
        end
      endcase
    end
  end

  assign o_Ready = rdy_p1;
`else
  assign o_Ready = !vld_p1 || i_Ready;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      tag_p1  <= '0;
      enc_p1  <= 1'b0;
    end else if (o_Ready) begin
      vld_p1 <= i_Valid;
      if (i_Valid) begin
        data_p1 <= perm_p0;
        tag_p1  <= i_Tag;
        enc_p1  <= i_fEncrypt;
      end
    end
  end
`endif

  assign o_Data     = data_p1;
  assign o_Tag      = tag_p1;
  assign o_fEncrypt = enc_p1;
  assign o_Valid    = vld_p1;

endmodule

// File: tb/tb_shift_row_pipe.sv
// Randomised and directed bench for shift_row_pipe (NB=4 and NB=8 instances).
module tb_shift_row_pipe;
  localparam int TAG_W = 4;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Rst;

  logic [127:0]     i_Data4, o_Data4;
  logic             i_fEncrypt4, o_fEncrypt4, i_Valid4, o_Valid4, i_Ready4, o_Ready4;
  logic [TAG_W-1:0] i_Tag4, o_Tag4;
  logic [255:0]     i_Data8, o_Data8;
  logic             i_fEncrypt8, o_fEncrypt8, i_Valid8, o_Valid8, i_Ready8, o_Ready8;
  logic [TAG_W-1:0] i_Tag8, o_Tag8;

  shift_row_pipe #(.NB(4), .TAG_W(TAG_W)) u_dut4 (
    .Clk(Clk), .Rst(Rst), .i_Data(i_Data4), .i_fEncrypt(i_fEncrypt4), .i_Tag(i_Tag4),
    .i_Valid(i_Valid4), .o_Ready(o_Ready4), .o_Data(o_Data4), .o_fEncrypt(o_fEncrypt4),
    .o_Tag(o_Tag4), .o_Valid(o_Valid4), .i_Ready(i_Ready4));

  shift_row_pipe #(.NB(8), .TAG_W(TAG_W)) u_dut8 (
    .Clk(Clk), .Rst(Rst), .i_Data(i_Data8), .i_fEncrypt(i_fEncrypt8), .i_Tag(i_Tag8),
    .i_Valid(i_Valid8), .o_Ready(o_Ready8), .o_Data(o_Data8), .o_fEncrypt(o_fEncrypt8),
    .o_Tag(o_Tag8), .o_Valid(o_Valid8), .i_Ready(i_Ready8));

  typedef struct {
    logic [127:0]     data;
    logic             enc;
    logic [TAG_W-1:0] tag;
  } blk_t;

  blk_t             q[$];
  logic [TAG_W-1:0] seen_tags[$];
  int               n_cmp = 0;
  int               n_err = 0;
  bit               last_acc;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: out[r][c] = in[r][(c +/- off_r) mod nb], byte k at bits [w-1-8k -: 8].
  function automatic logic [255:0] ref_perm(input logic [255:0] d, input int nb, input bit enc);
    logic [255:0] o;
    int w, r, c, off, sc;
    o = '0;
    w = 32 * nb;
    for (int k = 0; k < 4 * nb; k++) begin
      r   = k % 4;
      c   = k / 4;
      off = (nb == 8 && r >= 2) ? r + 1 : r;
      sc  = enc ? (c + off) % nb : (c - off + nb) % nb;
      o[w-1-8*k -: 8] = d[w-1-8*(4*sc+r) -: 8];
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock of the NB=4 instance; called just after a falling edge.
  task automatic cycle(input bit v, input logic [127:0] d, input bit e,
                       input logic [TAG_W-1:0] t, input bit rdy);
    bit exp_rdy, acc, drn;
    blk_t b;
    logic [255:0] p;
    i_Valid4 = v; i_Data4 = d; i_fEncrypt4 = e; i_Tag4 = t; i_Ready4 = rdy;
    #1;
`ifdef SHIFTROW_SKID_EN
    exp_rdy = (q.size() < 2);
`else
    exp_rdy = (q.size() == 0) || rdy;
`endif
    chk("o_Ready", {255'b0, o_Ready4}, {255'b0, exp_rdy});
    chk("o_Valid", {255'b0, o_Valid4}, {255'b0, q.size() > 0});
    if (q.size() > 0) begin
      chk("o_Data", {128'b0, o_Data4}, {128'b0, q[0].data});
      chk("o_Tag", {252'b0, o_Tag4}, {252'b0, q[0].tag});
      chk("o_fEncrypt", {255'b0, o_fEncrypt4}, {255'b0, q[0].enc});
    end
    acc = v && exp_rdy;
    drn = (q.size() > 0) && rdy;
    if (drn) seen_tags.push_back(o_Tag4);
    last_acc = acc;
    @(posedge Clk);
    if (drn) void'(q.pop_front());
    if (acc) begin
      p      = ref_perm({128'b0, d}, 4, e);
      b.data = p[127:0];
      b.enc  = e;
      b.tag  = t;
      q.push_back(b);
    end
    @(negedge Clk);
  endtask

  task automatic flush();
    for (int i = 0; i < 4 && q.size() > 0; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic p8(input logic [255:0] d, input bit e, output logic [255:0] res);
    i_Valid8 = 1'b1; i_Data8 = d; i_fEncrypt8 = e; i_Tag8 = 4'h9; i_Ready8 = 1'b1;
    @(posedge Clk);
    #1;
    i_Valid8 = 1'b0;
    chk("v8", {255'b0, o_Valid8}, 256'd1);
    chk("e8", {255'b0, o_fEncrypt8}, {255'b0, e});
    chk("d8", o_Data8, ref_perm(d, 8, e));
    res = o_Data8;
    @(negedge Clk);
  endtask

  localparam logic [127:0] PT4  = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
  localparam logic [127:0] ENC4 = 128'hA0B1C2D3_B0C1D2A3_C0D1A2B3_D0A1B2C3;
  localparam logic [127:0] DEC4 = 128'hA0D1C2B3_B0A1D2C3_C0B1A2D3_D0C1B2A3;

  initial begin
    logic [255:0] d8, e8, r8, tmp;
    logic [127:0] first_blk;
    int nxt;

    Rst = 1'b0;
    i_Valid4 = 0; i_Data4 = '0; i_fEncrypt4 = 0; i_Tag4 = '0; i_Ready4 = 1;
    i_Valid8 = 0; i_Data8 = '0; i_fEncrypt8 = 0; i_Tag8 = '0; i_Ready8 = 1;
    @(negedge Clk);
    chk("rst_valid", {255'b0, o_Valid4}, 256'd0);
    chk("rst_data", {128'b0, o_Data4}, 256'd0);
    chk("rst_ready", {255'b0, o_Ready4}, 256'd1);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // NB=8: byte k = k
    for (int k = 0; k < 32; k++) d8[255-8*k -: 8] = 8'(k);
    p8(d8, 1'b1, e8);
    chk("nb8_byte2", {248'b0, e8[255-16 -: 8]}, 256'h0E);
    chk("nb8_byte3", {248'b0, e8[255-24 -: 8]}, 256'h13);
    p8(e8, 1'b0, r8);
    chk("nb8_roundtrip", r8, d8);
    for (int i = 0; i < 4; i++) begin
      tmp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      p8(tmp, i[0], r8);
    end

    // NB=4 directed vectors
    cycle(1'b1, PT4, 1'b1, 4'h1, 1'b1);
    chk("enc4", {128'b0, o_Data4}, {128'b0, ENC4});
    chk("enc4_mode", {255'b0, o_fEncrypt4}, 256'd1);
    cycle(1'b1, PT4, 1'b0, 4'h2, 1'b1);
    chk("dec4", {128'b0, o_Data4}, {128'b0, DEC4});
    cycle(1'b1, ENC4, 1'b0, 4'h3, 1'b1);
    chk("rt4", {128'b0, o_Data4}, {128'b0, PT4});
    flush();

    // 8 tagged blocks, downstream stalled on cycles 3..5
    seen_tags.delete();
    nxt = 0;
    for (int cyc = 0; cyc < 40 && (nxt < 8 || q.size() > 0); cyc++) begin
      cycle(nxt < 8, rnd128(), cyc[0], TAG_W'(nxt), !(cyc >= 3 && cyc <= 5));
      if (last_acc) nxt++;
    end
    chk("tag_count", 256'(seen_tags.size()), 256'd8);
    for (int i = 0; i < seen_tags.size(); i++) chk("tag_order", {252'b0, seen_tags[i]}, 256'(i));

    // random traffic
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 3) != 0, rnd128(), 1'($urandom_range(0, 1)),
            TAG_W'($urandom), $urandom_range(0, 3) != 0);
    flush();

    // continuous flow, alternating mode
    for (int i = 0; i < 16; i++) cycle(1'b1, rnd128(), i[0], TAG_W'(i), 1'b1);
    flush();

    // asynchronous reset while holding a stalled block
    cycle(1'b1, rnd128(), 1'b1, 4'hA, 1'b0);
    cycle(1'b1, rnd128(), 1'b0, 4'hB, 1'b0);
    i_Valid4 = 1'b0;
    Rst = 1'b0;
    #1;
    chk("arst_valid", {255'b0, o_Valid4}, 256'd0);
    chk("arst_data", {128'b0, o_Data4}, 256'd0);
    chk("arst_tag", {252'b0, o_Tag4}, 256'd0);
    chk("arst_mode", {255'b0, o_fEncrypt4}, 256'd0);
    chk("arst_ready", {255'b0, o_Ready4}, 256'd1);
    q.delete();
    @(negedge Clk);
    Rst = 1'b1;
    first_blk = rnd128();
    cycle(1'b1, first_blk, 1'b1, 4'h5, 1'b1);
    tmp = ref_perm({128'b0, first_blk}, 4, 1'b1);
    chk("post_rst_first", {128'b0, o_Data4}, tmp);
    chk("post_rst_tag", {252'b0, o_Tag4}, 256'h5);
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
